fpadd_arbiter: RTL and testbench
================================

Name: fpadd_arbiter

Overview:
- Round-robin scheduler that shares one floating-point adder (Go/Ready handshake) between NREQ requesters.
- Sits between requester blocks and the adder top level.
- Per transaction: latches the winner's operands, pulses Go, waits for the adder's Ready to complete a low-then-high cycle, then returns the sum to the winner with a one-cycle Done pulse.

Parameters:
- NREQ, 4, number of requesters (2..8).
- EXPBITS, 8, exponent width of adder operands.
- MANTISSABITS, 23, mantissa width of adder operands. Operand width W = 1+EXPBITS+MANTISSABITS.
- TIMEOUT, 64, watchdog limit in cycles. Used only with the optional feature.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  NREQ  per-requester request level. Must be held with stable operands until that requester's Done.
- OpA  in  NREQ*W  operand A of each requester; slice i = OpA[i*W +: W].
- OpB  in  NREQ*W  operand B of each requester, same slicing.
- Grant  out  NREQ  one-hot; current owner of the adder; zero when idle.
- Done  out  NREQ  one-hot, one-cycle pulse; Result is valid for the flagged requester.
- Result  out  W  sum, registered; holds its value until the next Done.
- Error  out  1  asserted together with Done when the transaction timed out.
- AdderGo  out  1  start pulse to the adder.
- AdderA  out  W  registered operand A to the adder.
- AdderB  out  W  registered operand B to the adder.
- AdderReady  in  1  adder Ready: high when idle or result valid; drops after it samples Go.
- AdderResult  in  W  adder sum, valid while AdderReady is high after a completed operation.

Behaviour:
- Reset values: state IDLE; Grant, Done, AdderGo, Error = 0; Result, AdderA, AdderB = 0; round-robin pointer = 0 (requester 0 has highest priority). Reset mid-transaction aborts immediately: no Done is issued and the requester must re-request.
- State IDLE:
  - If Req != 0, pick the first set bit searching from the pointer upward, wrapping modulo NREQ.
  - Register Grant, AdderA and AdderB from the winner's slices.
  - Set the pointer to winner+1 (wrapping at NREQ), then go to ISSUE.
  - If Req == 0, stay in IDLE.
- State ISSUE: AdderGo = 1 for exactly this one cycle; go to WAITLOW.
- State WAITLOW: stay until AdderReady == 0, then go to WAITHIGH. This guards against stale Ready left over from the previous operation.
- State WAITHIGH: on AdderReady == 1, register Result from AdderResult, pulse Done[winner] for one cycle, and go to RESP.
- State RESP (one cycle): Grant = 0; return to IDLE.
  - Requester Req bits are not sampled here, so the finishing requester may drop Req during RESP.
  - A requester that still holds Req in IDLE is treated as a new request at lowest priority.
- Latency: Req seen in IDLE at cycle 0 → Grant at 1 → AdderGo high during cycle 1 → Done no earlier than cycle 1+adder latency+1. Minimum transaction is 5 cycles IDLE→IDLE.
- Grant is stable and one-hot from ISSUE through WAITHIGH. AdderA and AdderB are constant for the whole transaction.
- Req changes by non-granted requesters during a transaction are ignored until IDLE.
- Dropping Req of the granted requester mid-transaction is illegal: the transaction completes and Done still pulses.
- Simultaneous requests: grant order is strictly rotating, so with all NREQ requesting continuously each is served once per NREQ transactions.
- Outputs AdderGo, Done and Grant are never all zero while in ISSUE or WAIT states (Grant holds).

Optional Feature:
- Macro FPADD_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAITLOW and increments each cycle spent in WAITLOW/WAITHIGH.
  - When it reaches TIMEOUT, pulse Done[winner] with Error = 1 and Result = 0, then go to RESP.
  - The counter width is $clog2(TIMEOUT+1).
- Undefined: no counter; WAIT states wait indefinitely; Error is tied to 0.

Test Plan:
- Reset, then Req=4'b0100 with OpA=32'h3F800000 (1.0), OpB=32'h40000000 (2.0) → Grant=4'b0100 next cycle, one AdderGo pulse, Done=4'b0100 with Result=32'h40400000 (3.0), Error=0.
- Req=4'b1111 held continuously, distinct operands per requester → Done order 0,1,2,3,0. Each Result matches that requester's own operand sum.
- AdderReady held high for 2 cycles after AdderGo (stub adder) → arbiter stays in WAITLOW and no Done fires until Ready goes low then high.
- Reset asserted while in WAITHIGH → next cycle Grant=0, Done=0, AdderGo=0, pointer=0; a following Req=4'b0011 is granted to requester 0.
- With FPADD_ARB_TIMEOUT_EN and TIMEOUT=16, stub adder never raises Ready → Done pulses exactly 16 cycles after entering WAITLOW with Error=1, Result=0. Without the macro, no Done occurs within 100 cycles.
- Requester 2 drops Req during RESP while requester 3 raises Req → next Grant=4'b1000, no duplicate service of requester 2.

Source files
------------

// File: rtl/fpadd_arbiter.sv
// rtl/fpadd_arbiter.sv - round-robin arbiter sharing one Go/Ready floating-point adder among NREQ requesters
// Define FPADD_ARB_TIMEOUT_EN to add a TIMEOUT-cycle wait-state watchdog that completes with Error.
module fpadd_arbiter #(
  parameter int NREQ         = 4,
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23,
  parameter int TIMEOUT      = 64,
  localparam int W           = 1 + EXPBITS + MANTISSABITS
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [NREQ-1:0] Req,
  input  logic [NREQ*W-1:0] OpA,
  input  logic [NREQ*W-1:0] OpB,
  output logic [NREQ-1:0] Grant,
  output logic [NREQ-1:0] Done,
  output logic [W-1:0]    Result,
  output logic            Error,
  output logic            AdderGo,
  output logic [W-1:0]    AdderA,
  output logic [W-1:0]    AdderB,
  input  logic            AdderReady,
  input  logic [W-1:0]    AdderResult
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAITLOW, WAITHIGH, RESP} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic [PW-1:0] next_ptr;
  logic          found;
  logic [W-1:0]  op_a [NREQ];
  logic [W-1:0]  op_b [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign op_a[i] = OpA[i*W +: W];
    assign op_b[i] = OpB[i*W +: W];
  end

  // First requester at or above the pointer, wrapping; the pointer slot has top priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!found && Req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign next_ptr = PW'((int'(win) + 1) % NREQ);

`ifdef FPADD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          timed_out;
  // Fires on the edge where the count reaches TIMEOUT cycles spent waiting.
  assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));
`else
  // Watchdog compiled out: Error is constant 0.
  assign Error = (TIMEOUT < 0);
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      ptr     <= '0;
      Grant   <= '0;
      Done    <= '0;
      AdderGo <= 1'b0;
      Result  <= '0;
      AdderA  <= '0;
      AdderB  <= '0;
`ifdef FPADD_ARB_TIMEOUT_EN
      Error    <= 1'b0;
      wait_cnt <= '0;
`endif
    end else begin
      Done    <= '0;
      AdderGo <= 1'b0;
`ifdef FPADD_ARB_TIMEOUT_EN
      Error   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            Grant   <= NREQ'(1) << win;
            AdderA  <= op_a[win];
            AdderB  <= op_b[win];
            ptr     <= next_ptr;
            AdderGo <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAITLOW;
`ifdef FPADD_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        // A Ready still high here is left over from the previous operation.
        WAITLOW: begin
`ifdef FPADD_ARB_TIMEOUT_EN
          wait_cnt <= wait_cnt + CW'(1);
          if (timed_out) begin
            Done   <= Grant;
            Grant  <= '0;
            Result <= '0;
            Error  <= 1'b1;
            state  <= RESP;
          end else if (!AdderReady) begin
            state <= WAITHIGH;
          end
`else
          if (!AdderReady) state <= WAITHIGH;
`endif
        end
        WAITHIGH: begin
`ifdef FPADD_ARB_TIMEOUT_EN
          wait_cnt <= wait_cnt + CW'(1);
`endif
          if (AdderReady) begin
            Result <= AdderResult;
            Done   <= Grant;
            Grant  <= '0;
            state  <= RESP;
          end
`ifdef FPADD_ARB_TIMEOUT_EN
          else if (timed_out) begin
            Done   <= Grant;
            Grant  <= '0;
            Result <= '0;
            Error  <= 1'b1;
            state  <= RESP;
          end
`endif
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpadd_arbiter.sv
// tb/tb_fpadd_arbiter.sv - randomized self-checking bench for fpadd_arbiter with a stub Go/Ready adder
// Timeout scenario follows FPADD_ARB_TIMEOUT_EN.
module tb_fpadd_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           Clock = 1'b0;
  logic           Reset;
  logic [N-1:0]   Req;
  logic [N*W-1:0] OpA;
  logic [N*W-1:0] OpB;
  logic [N-1:0]   Grant;
  logic [N-1:0]   Done;
  logic [W-1:0]   Result;
  logic           Error;
  logic           AdderGo;
  logic [W-1:0]   AdderA;
  logic [W-1:0]   AdderB;
  logic           AdderReady;
  logic [W-1:0]   AdderResult;

  fpadd_arbiter #(.NREQ(N), .EXPBITS(8), .MANTISSABITS(23), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .OpA(OpA), .OpB(OpB),
    .Grant(Grant), .Done(Done), .Result(Result), .Error(Error),
    .AdderGo(AdderGo), .AdderA(AdderA), .AdderB(AdderB),
    .AdderReady(AdderReady), .AdderResult(AdderResult)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic real sp2r(input logic [31:0] a);
    logic [63:0] d;
    logic [10:0] e;
    if (a[30:0] == 31'd0) return 0.0;
    e = {3'b000, a[30:23]} + 11'd896;
    d = {a[31], e, a[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(sp2r(a) + sp2r(b));
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] rnd_f();
    return {1'b0, 8'($urandom_range(120, 135)), 23'($urandom)};
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] one;
    one = 1;
    if (w < 0) return '0;
    return one << w;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  // stub adder: Ready stays high cur_stale cycles after Go, low cur_lat cycles, then high with the sum
  int          stale = 0, lat = 1, cur_stale = 0, cur_lat = 1;
  bit          hang = 0, rand_timing = 0;
  int          phase, scnt;
  logic [31:0] pend, s_a, s_b;
  logic        s_go, s_rst;

  initial begin
    AdderReady  = 1'b1;
    AdderResult = '0;
    phase = 0;
    scnt  = 0;
    forever begin
      @(negedge Clock);
      s_go = AdderGo; s_rst = Reset; s_a = AdderA; s_b = AdderB;
      @(posedge Clock);
      #1;
      if (s_rst) begin
        phase = 0;
        AdderReady = 1'b1;
      end else if (s_go) begin
        if (rand_timing) begin
          cur_stale = $urandom_range(0, 2);
          cur_lat   = $urandom_range(1, 4);
        end else begin
          cur_stale = stale;
          cur_lat   = lat;
        end
        pend = fadd(s_a, s_b);
        if (cur_stale == 0) begin
          AdderReady = 1'b0; phase = 2; scnt = cur_lat;
        end else begin
          phase = 1; scnt = cur_stale;
        end
      end else if (phase == 1) begin
        if (scnt == 1) begin
          AdderReady = 1'b0; phase = 2; scnt = cur_lat;
        end else scnt--;
      end else if (phase == 2 && !hang) begin
        if (scnt == 1) begin
          AdderReady = 1'b1; AdderResult = pend; phase = 0;
        end else scnt--;
      end
    end
  end

  // transaction-level reference: rotating pointer, winner operands, expected sum and completion time
  int             cyc = 0, ptr_m = 0, win_m = 0, go_cyc = 0, w = 0;
  bit             active = 0, expect_to = 0;
  logic [N-1:0]   req_prev = '0;
  logic [N*W-1:0] opa_prev = '0, opb_prev = '0;
  logic [31:0]    exp_a = '0, exp_b = '0;
  int             done_cnt = 0;
  int             done_tally[N] = '{default: 0};

  always @(negedge Clock) begin
    cyc++;
    if (Reset) begin
      ptr_m  = 0;
      active = 0;
    end else if (!active && Grant != '0) begin
      w = pick(req_prev, ptr_m);
      check("mon_grant", Grant, onehot(w));
      check("mon_go", AdderGo, 1'b1);
      if (w >= 0) begin
        exp_a = opa_prev[w*W +: W];
        exp_b = opb_prev[w*W +: W];
      end
      check("mon_adder_a", AdderA, exp_a);
      check("mon_adder_b", AdderB, exp_b);
      win_m  = w;
      ptr_m  = (w + 1) % N;
      active = 1;
      go_cyc = cyc;
    end else if (active) begin
      if (Done != '0) begin
        check("mon_done", Done, onehot(win_m));
        check("mon_when", cyc, expect_to ? go_cyc + 1 + TO : go_cyc + 2 + cur_stale + cur_lat);
        check("mon_result", Result, expect_to ? 32'd0 : fadd(exp_a, exp_b));
        check("mon_error", Error, expect_to);
        if (win_m >= 0) done_tally[win_m]++;
        done_cnt++;
        active = 0;
      end else begin
        if (Grant != onehot(win_m)) check("mon_grant_hold", Grant, onehot(win_m));
        if (AdderGo) check("mon_go_extra", AdderGo, 1'b0);
        if (AdderA != exp_a) check("mon_a_hold", AdderA, exp_a);
      end
    end else if (Done != '0) begin
      check("mon_spurious_done", Done, '0);
    end
    req_prev = Req;
    opa_prev = OpA;
    opb_prev = OpB;
  end

  logic [31:0] opa_t[N], opb_t[N];

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      OpA[i*W +: W] = opa_t[i];
      OpB[i*W +: W] = opb_t[i];
    end
  endtask

  task automatic do_reset();
    @(posedge Clock);
    #1 Reset = 1'b1;
    Req = '0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
  endtask

  task automatic wait_grant();
    for (int n = 0; n < 50; n++) begin
      @(negedge Clock);
      if (Grant != '0) return;
    end
    check("grant_wait", Grant != '0, 1'b1);
  endtask

  task automatic wait_done(output int n);
    for (n = 1; n <= 300; n++) begin
      @(negedge Clock);
      if (Done != '0) return;
    end
    check("done_wait", Done != '0, 1'b1);
  endtask

  int n, cnt, start, seen[N];
  int t2_ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    Reset = 1'b1; Req = '0; OpA = '0; OpB = '0;
    for (int i = 0; i < N; i++) begin opa_t[i] = '0; opb_t[i] = '0; end
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("rst_grant", Grant, '0);
    check("rst_done", Done, '0);
    check("rst_go", AdderGo, 1'b0);
    check("rst_error", Error, 1'b0);
    check("rst_result", Result, '0);
    check("rst_adder_a", AdderA, '0);
    check("rst_adder_b", AdderB, '0);
    @(posedge Clock);
    #1 Reset = 1'b0;

    // 1.0 + 2.0 on requester 2
    stale = 0; lat = 2;
    opa_t[2] = 32'h3F800000; opb_t[2] = 32'h40000000; apply();
    Req = 4'b0100;
    wait_grant();
    check("t1_grant", Grant, 4'b0100);
    check("t1_go", AdderGo, 1'b1);
    wait_done(n);
    check("t1_latency", n, 4);
    check("t1_done", Done, 4'b0100);
    check("t1_result", Result, 32'h40400000);
    check("t1_error", Error, 1'b0);
    #1 Req = '0;

    // all four requesting continuously
    do_reset();
    lat = 1;
    for (int i = 0; i < N; i++) begin opa_t[i] = rnd_f(); opb_t[i] = rnd_f(); end
    apply();
    Req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(n);
      check("t2_order", idx_of(Done), t2_ord[k]);
      check("t2_result", Result, fadd(opa_t[t2_ord[k]], opb_t[t2_ord[k]]));
    end
    #1 Req = '0;
    repeat (5) @(negedge Clock);

    // stale Ready held two cycles after Go
    stale = 2; lat = 1;
    opa_t[0] = rnd_f(); opb_t[0] = rnd_f(); apply();
    @(posedge Clock);
    #1 Req = 4'b0001;
    wait_grant();
    wait_done(n);
    check("t3_latency", n, 5);
    check("t3_result", Result, fadd(opa_t[0], opb_t[0]));
    #1 Req = '0;
    stale = 0;
    repeat (3) @(negedge Clock);

    // requester 2 drops during RESP while requester 3 raises
    opa_t[2] = rnd_f(); opb_t[2] = rnd_f(); opa_t[3] = rnd_f(); opb_t[3] = rnd_f(); apply();
    @(posedge Clock);
    #1 Req = 4'b0100;
    wait_grant();
    check("t6_first", Grant, 4'b0100);
    wait_done(n);
    #1 Req = 4'b1000;
    wait_grant();
    check("t6_next_grant", Grant, 4'b1000);
    wait_done(n);
    check("t6_done", Done, 4'b1000);
    #1 Req = '0;
    cnt = 0;
    repeat (10) begin
      @(negedge Clock);
      if (Done != '0) cnt++;
    end
    check("t6_no_dup", cnt, 0);

    // reset while waiting for Ready high; requester 0 was just served so pointer is 1
    lat = 30;
    @(posedge Clock);
    #1 Req = 4'b0001;
    wait_grant();
    repeat (3) @(negedge Clock);
    @(posedge Clock);
    #1 Reset = 1'b1; Req = '0; lat = 1;
    @(posedge Clock);
    #1 Reset = 1'b0; Req = 4'b0011;
    @(negedge Clock);
    check("t4_grant", Grant, '0);
    check("t4_done", Done, '0);
    check("t4_go", AdderGo, 1'b0);
    wait_grant();
    check("t4_ptr_zero", Grant, 4'b0001);
    wait_done(n);
    check("t4_done_req0", Done, 4'b0001);
    #1 Req = '0;

    // adder never raises Ready
    do_reset();
    hang = 1;
`ifdef FPADD_ARB_TIMEOUT_EN
    expect_to = 1;
`endif
    opa_t[3] = rnd_f(); opb_t[3] = rnd_f(); apply();
    Req = 4'b1000;
    wait_grant();
`ifdef FPADD_ARB_TIMEOUT_EN
    wait_done(n);
    check("t5_to_latency", n, TO + 1);
    check("t5_to_done", Done, 4'b1000);
    check("t5_to_error", Error, 1'b1);
    check("t5_to_result", Result, 32'd0);
`else
    cnt = 0;
    repeat (100) begin
      @(negedge Clock);
      if (Done != '0) cnt++;
    end
    check("t5_no_done", cnt, 0);
    check("t5_grant_held", Grant, 4'b1000);
    check("t5_error", Error, 1'b0);
`endif
    #1 Req = '0;
    hang = 0;
    do_reset();
    expect_to = 0;

    // randomized traffic and adder timing against the reference
    rand_timing = 1;
    do_reset();
    for (int i = 0; i < N; i++) seen[i] = done_tally[i];
    start = done_cnt;
    for (int c = 0; c < 6000; c++) begin
      @(posedge Clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (done_tally[i] != seen[i]) begin
          seen[i] = done_tally[i];
          Req[i] = 1'b0;
        end else if (!Req[i] && done_cnt - start < 40 && $urandom_range(0, 3) == 0) begin
          opa_t[i] = rnd_f();
          opb_t[i] = rnd_f();
          Req[i] = 1'b1;
        end
      end
      apply();
      if (done_cnt - start >= 40 && Req == '0) break;
    end
    check("rand_progress", done_cnt - start >= 40, 1'b1);
    check("rand_drained", Req, '0);
    repeat (5) @(negedge Clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
